// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Operation encodings for alu_1bit and the serial controller states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_INC  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUBB = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_serial_ctrl_if.sv
// ============================================================================
// Module   : alu_serial_ctrl_if
// Purpose  : Issue-side bus of the serial ALU controller (zero_o present only
//            when ALU_SERIAL_ZERO_FLAG_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       sel_i;
  logic             cin_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             cout_o;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             zero_o;
`endif

  modport master (
    output start_i, sel_i, cin_i, a_i, b_i,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    input  zero_o,
`endif
    input  busy_o, done_o, result_o, cout_o
  );

  modport slave (
    input  start_i, sel_i, cin_i, a_i, b_i,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output zero_o,
`endif
    output busy_o, done_o, result_o, cout_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_1bit.sv
// ============================================================================
// Module   : alu_1bit
// Purpose  : One-bit ALU slice; arithmetic ops chain carry through cin/cout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_1bit
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [3:0] sel_i,
  output logic       f_o,
  output logic       cout_o
);

  always_comb begin
    f_o    = 1'b0;
    cout_o = 1'b0;
    case (sel_i)
      OP_INC: begin
        f_o    = a_i ^ cin_i;
        cout_o = a_i & cin_i;
      end
      OP_ADD: begin
        f_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
      end
      OP_SUBB: begin
        f_o    = a_i ^ ~b_i ^ cin_i;
        cout_o = (a_i & ~b_i) | (cin_i & (a_i ^ ~b_i));
      end
      // A plus all-ones plus carry: A - 1 + cin
      OP_DEC: begin
        f_o    = ~(a_i ^ cin_i);
        cout_o = a_i | cin_i;
      end
      OP_AND:  f_o = a_i & b_i;
      OP_OR:   f_o = a_i | b_i;
      OP_XOR:  f_o = a_i ^ b_i;
      OP_NOT:  f_o = ~a_i;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
// Module   : alu_serial_ctrl
// Purpose  : Bit-serial WIDTH-bit ALU built around one alu_1bit slice; shifts
//            done in one cycle. Optional zero flag: ALU_SERIAL_ZERO_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_serial_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   shifted;
  logic [3:0]         sel_q, sel_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               slice_f, slice_c;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic               acc_q, acc_d;
  logic               zero_q, zero_d;
`endif

  alu_1bit u_slice (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sel_i  (sel_q),
    .f_o    (slice_f),
    .cout_o (slice_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      acc_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      acc_q    <= acc_d;
      zero_q   <= zero_d;
`endif
    end
  end

  // Outputs are loaded on the edge entering DONE so they are valid with done_o.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    shifted  = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    acc_d    = acc_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          a_sh_d  = bus.a_i;
          b_sh_d  = bus.b_i;
          sel_d   = bus.sel_i;
          carry_d = bus.cin_i;
          cnt_d   = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          acc_d   = 1'b0;
`endif
          state_d = bus.sel_i[3] ? ST_SHIFT : ST_RUN;
        end
      end
      ST_RUN: begin
        res_sh_d = {slice_f, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = slice_c;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        acc_d    = acc_q | slice_f;
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = ST_DONE;
          result_d = res_sh_d;
          cout_d   = sel_q[2] ? 1'b0 : slice_c;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          zero_d   = ~(acc_q | slice_f);
`endif
        end
      end
      ST_SHIFT: begin
        if (sel_q[2]) begin
          shifted = {a_sh_q[WIDTH-2:0], 1'b0};
          carry_d = a_sh_q[WIDTH-1];
        end else begin
          shifted = {1'b0, a_sh_q[WIDTH-1:1]};
          carry_d = a_sh_q[0];
        end
        res_sh_d = shifted;
        result_d = shifted;
        cout_d   = carry_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        zero_d   = (shifted == '0);
`endif
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy_o   = (state_q == ST_RUN) || (state_q == ST_SHIFT);
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.result_o = result_q;
  assign bus.cout_o   = cout_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  assign bus.zero_o   = zero_q;
`endif

endmodule

`default_nettype wire
